// File: rtl/cs_serial_ctrl.sv
// cs_serial_ctrl: 9-sample window sequencer computing Y = (sum + 9*appr) >> 3 with one shared adder and one comparator
module cs_serial_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] X,
  input  logic       x_valid,
  output logic       x_ready,
  output logic [9:0] Y,
  output logic       y_valid
);
  typedef enum logic [1:0] {IDLE, SUM, SCAN, OUT} state_t;
  state_t      state_q;
  logic [7:0]  win_q [0:8];
  logic [3:0]  wptr_q, fill_q, idx_q;
  logic [11:0] acc_q, acc_d;
  logic [7:0]  avg_q, appr_q, cur_w, avg_w;
  logic [12:0] y_w;
  assign x_ready = state_q == IDLE;
  assign cur_w   = win_q[idx_q];
  assign acc_d   = acc_q + {4'd0, cur_w};
  assign avg_w   = 8'(acc_d / 12'd9);
  assign y_w     = {1'b0, acc_q} + 13'd9 * {5'd0, appr_q};
  // FSM: accept into circular window, then serial SUM and SCAN passes, then register result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      wptr_q  <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      avg_q   <= '0;
      appr_q  <= '0;
      Y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state_q)
        IDLE: if (x_valid) begin
          win_q[wptr_q] <= X;
          wptr_q <= wptr_q == 4'd8 ? 4'd0 : wptr_q + 4'd1;
          fill_q <= fill_q == 4'd9 ? 4'd9 : fill_q + 4'd1;
          if (fill_q >= 4'd8) begin
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= SUM;
          end
        end
        SUM: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd8) begin
            avg_q   <= avg_w;
            appr_q  <= '0;
            idx_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (cur_w <= avg_q && cur_w > appr_q) appr_q <= cur_w;
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd8) begin
            idx_q   <= '0;
            state_q <= OUT;
          end
        end
        OUT: begin
          Y       <= 10'(y_w >> 3);
          y_valid <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cs_serial_ctrl.sv
// tb_cs_serial_ctrl: randomized self-checking bench against a window-set reference model
module tb_cs_serial_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x_valid = 1'b0;
  logic [7:0] X = '0;
  logic       x_ready, y_valid;
  logic [9:0] Y;
  int vecs = 0;
  int errs = 0;
  int nacc = 0;
  logic [7:0] win[$];

  cs_serial_ctrl dut (.clk(clk), .reset(reset), .X(X), .x_valid(x_valid),
                      .x_ready(x_ready), .Y(Y), .y_valid(y_valid));

  always #5 clk = ~clk;

  function automatic logic [9:0] model_y();
    int s, a, ap;
    s = 0;
    foreach (win[i]) s += win[i];
    a = s / 9;
    ap = 0;
    foreach (win[i]) if (win[i] <= a && win[i] > ap) ap = win[i];
    return 10'((s + 9 * ap) >> 3);
  endfunction

  task automatic do_reset(input bit with_x);
    @(negedge clk);
    reset = 1'b1;
    x_valid = with_x;
    X = 8'd200;
    @(posedge clk);
    #1;
    reset = 1'b0;
    x_valid = 1'b0;
    win.delete();
    nacc = 0;
  endtask

  task automatic accept(input logic [7:0] x, input bit hold);
    int n;
    @(negedge clk);
    X = x;
    x_valid = 1'b1;
    n = 0;
    while (!x_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (x_ready !== 1'b1) begin
      errs++;
      $display("FAIL accept_wait: x_ready got %b want 1", x_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) x_valid = 1'b0;
    win.push_back(x);
    if (win.size() > 9) void'(win.pop_front());
    nacc++;
  endtask

  task automatic check_result(input string name, input int exp, input bit hold);
    int k;
    logic [9:0] m;
    m = model_y();
    for (k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (hold) begin
        X = 8'($urandom);
        if (k >= 19) x_valid = 1'b0;
      end
      if (y_valid) break;
      vecs++;
      if (x_ready !== 1'b0) begin
        errs++;
        $display("FAIL %s busy_ready: cycle %0d x_ready got %b want 0", name, k, x_ready);
      end
    end
    vecs++;
    if (k !== 19) begin
      errs++;
      $display("FAIL %s latency: got %0d want 19", name, k);
    end
    vecs++;
    if (Y !== m) begin
      errs++;
      $display("FAIL %s Y_model: got %0d want %0d", name, Y, m);
    end
    if (exp >= 0) begin
      vecs++;
      if (Y !== 10'(exp)) begin
        errs++;
        $display("FAIL %s Y_const: got %0d want %0d", name, Y, exp);
      end
    end
    vecs++;
    if (x_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s ready_at_out: got %b want 1", name, x_ready);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (y_valid !== 1'b0) begin
      errs++;
      $display("FAIL %s pulse_width: y_valid got %b want 0", name, y_valid);
    end
  endtask

  task automatic push(input logic [7:0] x, input bit hold, input int exp, input string name);
    accept(x, hold);
    if (nacc >= 9) check_result(name, exp, hold);
    else begin
      vecs++;
      if (y_valid !== 1'b0) begin
        errs++;
        $display("FAIL %s early_result: sample %0d y_valid got %b want 0", name, nacc, y_valid);
      end
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vecs++;
    if (x_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready: got %b want 1", x_ready);
    end
    vecs++;
    if (y_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_yvalid: got %b want 0", y_valid);
    end
    vecs++;
    if (Y !== 10'd0) begin
      errs++;
      $display("FAIL reset_Y: got %0d want 0", Y);
    end
  endtask

  task automatic test_tens();
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) push(8'd10, 1'b0, 22, "tens");
  endtask

  task automatic test_ramp();
    do_reset(1'b0);
    for (int i = 1; i <= 9; i++) push(8'(i), 1'b0, 11, "ramp");
    push(8'd100, 1'b0, 28, "ramp_100");
  endtask

  task automatic test_max();
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) push(8'd255, 1'b0, 573, "max");
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 30; i++)
      push(i[0] ? 8'($urandom) : 8'($urandom_range(0, 20)), 1'b0, -1, "random");
  endtask

  task automatic test_hold();
    do_reset(1'b0);
    for (int i = 0; i < 14; i++) push(8'($urandom), 1'b1, -1, "hold");
    x_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) accept(8'($urandom), 1'b0);
    repeat (12) @(posedge clk);
    do_reset(1'b1);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      vecs++;
      if (y_valid !== 1'b0) begin
        errs++;
        $display("FAIL abort_yvalid: cycle %0d got %b want 0", i, y_valid);
      end
    end
    vecs++;
    if (Y !== 10'd0) begin
      errs++;
      $display("FAIL abort_Y: got %0d want 0", Y);
    end
    for (int i = 0; i < 9; i++) push(8'($urandom), 1'b0, -1, "after_abort");
  endtask

  initial begin
    test_reset();
    test_tens();
    test_ramp();
    test_max();
    test_random();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
